// File: rtl/riscv_pipe_skid_register.sv
// Valid/ready pipeline stage register for the RV32I core. It carries a control bundle and a data bundle.
// The stage is built either as a two-entry skid buffer with a registered in_ready, or as a single register.
module riscv_pipe_skid_register #(
  parameter int unsigned           CTRL_WIDTH = 16,
  parameter int unsigned           DATA_WIDTH = 192,
  parameter logic [CTRL_WIDTH-1:0] CTRL_INIT  = '0,
  parameter logic [DATA_WIDTH-1:0] DATA_INIT  = '0,
  parameter bit                    SKID_EN    = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_flush,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [CTRL_WIDTH-1:0] i_in_ctrl,
  input  logic [DATA_WIDTH-1:0] i_in_data,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [CTRL_WIDTH-1:0] o_out_ctrl,
  output logic [DATA_WIDTH-1:0] o_out_data,
  output logic [1:0]            o_occupancy
);

  logic                  main_valid;
  logic [CTRL_WIDTH-1:0] main_ctrl;
  logic [DATA_WIDTH-1:0] main_data;
  logic                  in_fire;
  logic                  out_fire;

  assign in_fire     = i_in_valid & o_in_ready;
  assign out_fire    = main_valid & i_out_ready;
  assign o_out_valid = main_valid;
  assign o_out_ctrl  = main_valid ? main_ctrl : CTRL_INIT;
  assign o_out_data  = main_data;

  generate
    if (SKID_EN) begin : g_skid
      logic                  skid_valid;
      logic [CTRL_WIDTH-1:0] skid_ctrl;
      logic [DATA_WIDTH-1:0] skid_data;

      // in_ready comes straight from the skid_valid flop, so upstream never sees i_out_ready combinationally
      assign o_in_ready  = ~skid_valid;
      assign o_occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

      always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
          main_valid <= 1'b0;
          main_ctrl  <= CTRL_INIT;
          main_data  <= DATA_INIT;
          skid_valid <= 1'b0;
          skid_ctrl  <= CTRL_INIT;
          skid_data  <= DATA_INIT;
        end else if (i_flush) begin
          main_valid <= 1'b0;
          skid_valid <= 1'b0;
          main_ctrl  <= CTRL_INIT;
          skid_ctrl  <= CTRL_INIT;
        end else if (skid_valid) begin
          if (out_fire) begin
            main_ctrl  <= skid_ctrl;
            main_data  <= skid_data;
            skid_valid <= 1'b0;
          end
        end else if (main_valid) begin
          if (in_fire && out_fire) begin
            main_ctrl <= i_in_ctrl;
            main_data <= i_in_data;
          end else if (in_fire) begin
            skid_ctrl  <= i_in_ctrl;
            skid_data  <= i_in_data;
            skid_valid <= 1'b1;
          end else if (out_fire) begin
            main_valid <= 1'b0;
          end
        end else if (in_fire) begin
          main_valid <= 1'b1;
          main_ctrl  <= i_in_ctrl;
          main_data  <= i_in_data;
        end
      end
    end else begin : g_single
      assign o_in_ready  = ~main_valid | i_out_ready;
      assign o_occupancy = {1'b0, main_valid};

      always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
          main_valid <= 1'b0;
          main_ctrl  <= CTRL_INIT;
          main_data  <= DATA_INIT;
        end else if (i_flush) begin
          main_valid <= 1'b0;
          main_ctrl  <= CTRL_INIT;
        end else if (in_fire) begin
          main_valid <= 1'b1;
          main_ctrl  <= i_in_ctrl;
          main_data  <= i_in_data;
        end else if (out_fire) begin
          main_valid <= 1'b0;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_riscv_pipe_skid_register.sv
// Bench for riscv_pipe_skid_register: one skid build and one single-register build, driven by vectors,
// directed sequences and random traffic checked against a queue model.
module tb_riscv_pipe_skid_register;

  logic         clk = 1'b0;
  logic         rst_n;
  // skid build (SKID_EN=1)
  logic         flush, in_valid, out_ready;
  logic [15:0]  in_ctrl;
  logic [191:0] in_data;
  logic         in_ready, out_valid;
  logic [15:0]  out_ctrl;
  logic [191:0] out_data;
  logic [1:0]   occ;
  // single-register build (SKID_EN=0)
  logic         flush_s, in_valid_s, out_ready_s;
  logic [15:0]  in_ctrl_s;
  logic [191:0] in_data_s;
  logic         in_ready_s, out_valid_s;
  logic [15:0]  out_ctrl_s;
  logic [191:0] out_data_s;
  logic [1:0]   occ_s;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  riscv_pipe_skid_register #(.SKID_EN(1'b1)) dut (
    .i_clk(clk), .i_rstn(rst_n), .i_flush(flush),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_ctrl(in_ctrl), .i_in_data(in_data),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_ctrl(out_ctrl), .o_out_data(out_data),
    .o_occupancy(occ)
  );

  riscv_pipe_skid_register #(.SKID_EN(1'b0)) dut_s (
    .i_clk(clk), .i_rstn(rst_n), .i_flush(flush_s),
    .i_in_valid(in_valid_s), .o_in_ready(in_ready_s), .i_in_ctrl(in_ctrl_s), .i_in_data(in_data_s),
    .o_out_valid(out_valid_s), .i_out_ready(out_ready_s), .o_out_ctrl(out_ctrl_s), .o_out_data(out_data_s),
    .o_occupancy(occ_s)
  );

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        flush;
    logic        in_valid;
    logic [15:0] in_ctrl;
    logic        out_ready;
    logic        exp_valid;
    logic [15:0] exp_ctrl;
    logic [1:0]  exp_occ;
    logic        exp_ready;
  } vec_t;

  function automatic vec_t mk(input logic f, input logic iv, input logic [15:0] ic, input logic ordy,
                              input logic ev, input logic [15:0] ec, input logic [1:0] eo, input logic er);
    vec_t v;
    v.flush = f; v.in_valid = iv; v.in_ctrl = ic; v.out_ready = ordy;
    v.exp_valid = ev; v.exp_ctrl = ec; v.exp_occ = eo; v.exp_ready = er;
    return v;
  endfunction

  typedef struct packed {
    logic [15:0]  c;
    logic [191:0] d;
  } beat_t;

  vec_t  vecs[24];
  beat_t q0[$];
  beat_t q1[$];

  initial begin
    rst_n = 1'b0;
    flush = 0; in_valid = 0; in_ctrl = '0; in_data = '0; out_ready = 0;
    flush_s = 0; in_valid_s = 0; in_ctrl_s = '0; in_data_s = '0; out_ready_s = 0;

    // inputs applied for one cycle; expectations are the outputs seen before that cycle's edge
    // stream 1,2,3 with out_ready held high
    vecs[0]  = mk(0, 1, 16'h0001, 1, 0, 16'h0000, 0, 1);
    vecs[1]  = mk(0, 1, 16'h0002, 1, 1, 16'h0001, 1, 1);
    vecs[2]  = mk(0, 1, 16'h0003, 1, 1, 16'h0002, 1, 1);
    vecs[3]  = mk(0, 0, 16'h0000, 1, 1, 16'h0003, 1, 1);
    vecs[4]  = mk(0, 0, 16'h0000, 1, 0, 16'h0000, 0, 1);
    // backpressure fill: A, B, then C offered while full
    vecs[5]  = mk(0, 1, 16'h0011, 0, 0, 16'h0000, 0, 1);
    vecs[6]  = mk(0, 1, 16'h0022, 0, 1, 16'h0011, 1, 1);
    vecs[7]  = mk(0, 1, 16'h0033, 0, 1, 16'h0011, 2, 0);
    vecs[8]  = mk(0, 1, 16'h0033, 0, 1, 16'h0011, 2, 0);
    vecs[9]  = mk(0, 1, 16'h0033, 1, 1, 16'h0011, 2, 0);
    vecs[10] = mk(0, 1, 16'h0033, 1, 1, 16'h0022, 1, 1);
    vecs[11] = mk(0, 0, 16'h0000, 1, 1, 16'h0033, 1, 1);
    vecs[12] = mk(0, 0, 16'h0000, 1, 0, 16'h0000, 0, 1);
    // flush while in the skid state, with 0x44 offered alongside
    vecs[13] = mk(0, 1, 16'h0011, 0, 0, 16'h0000, 0, 1);
    vecs[14] = mk(0, 1, 16'h0022, 0, 1, 16'h0011, 1, 1);
    vecs[15] = mk(1, 1, 16'h0044, 0, 1, 16'h0011, 2, 0);
    vecs[16] = mk(0, 0, 16'h0000, 1, 0, 16'h0000, 0, 1);
    vecs[17] = mk(0, 0, 16'h0000, 1, 0, 16'h0000, 0, 1);
    // flush beats an accepted beat from empty
    vecs[18] = mk(1, 1, 16'h0055, 1, 0, 16'h0000, 0, 1);
    vecs[19] = mk(0, 0, 16'h0000, 1, 0, 16'h0000, 0, 1);
    // simultaneous in/out while full
    vecs[20] = mk(0, 1, 16'h0066, 1, 0, 16'h0000, 0, 1);
    vecs[21] = mk(0, 1, 16'h0077, 1, 1, 16'h0066, 1, 1);
    vecs[22] = mk(0, 0, 16'h0000, 1, 1, 16'h0077, 1, 1);
    vecs[23] = mk(0, 0, 16'h0000, 1, 0, 16'h0000, 0, 1);

    #2;
    check("reset_valid", 192'(out_valid), 192'(1'b0));
    check("reset_ready", 192'(in_ready), 192'(1'b1));
    check("reset_ready_single", 192'(in_ready_s), 192'(1'b1));
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 24; i++) begin
      flush = vecs[i].flush; in_valid = vecs[i].in_valid; out_ready = vecs[i].out_ready;
      in_ctrl = vecs[i].in_ctrl; in_data = 192'(vecs[i].in_ctrl);
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), 192'(out_valid), 192'(vecs[i].exp_valid));
      check($sformatf("vec%0d_ctrl", i), 192'(out_ctrl), 192'(vecs[i].exp_ctrl));
      check($sformatf("vec%0d_occ", i), 192'(occ), 192'(vecs[i].exp_occ));
      check($sformatf("vec%0d_ready", i), 192'(in_ready), 192'(vecs[i].exp_ready));
      if (vecs[i].exp_valid)
        check($sformatf("vec%0d_data", i), out_data, 192'(vecs[i].exp_ctrl));
      @(posedge clk); #1;
    end
    flush = 0; in_valid = 0; out_ready = 0;

    // single-register build: stall drops in_ready, raising out_ready restores it combinationally
    in_valid_s = 1; in_ctrl_s = 16'h0081; in_data_s = 192'h81; out_ready_s = 0;
    @(negedge clk);
    check("single_empty_ready", 192'(in_ready_s), 192'(1'b1));
    @(posedge clk); #1;
    in_ctrl_s = 16'h0082; in_data_s = 192'h82;
    @(negedge clk);
    check("single_stall_ready", 192'(in_ready_s), 192'(1'b0));
    check("single_stall_ctrl", 192'(out_ctrl_s), 192'(16'h0081));
    out_ready_s = 1; #1;
    check("single_comb_ready", 192'(in_ready_s), 192'(1'b1));
    @(posedge clk); #1;
    in_ctrl_s = 16'h0083; in_data_s = 192'h83;
    @(negedge clk);
    check("single_pass_ctrl82", 192'(out_ctrl_s), 192'(16'h0082));
    check("single_pass_occ", 192'(occ_s), 192'(2'd1));
    @(posedge clk); #1;
    in_valid_s = 0;
    @(negedge clk);
    check("single_pass_data83", out_data_s, 192'h83);
    @(posedge clk); #1;
    out_ready_s = 0;
    @(negedge clk);
    check("single_drained", 192'(out_valid_s), 192'(1'b0));
    @(posedge clk); #1;

    // async reset while two beats are held
    in_valid = 1; in_ctrl = 16'h00a1; in_data = 192'ha1; out_ready = 0;
    @(posedge clk); #1;
    in_ctrl = 16'h00a2; in_data = 192'ha2;
    @(posedge clk); #1;
    in_valid = 0;
    @(negedge clk);
    check("pre_reset_occ", 192'(occ), 192'(2'd2));
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 192'(out_valid), 192'(1'b0));
    check("async_rst_ctrl", 192'(out_ctrl), 192'(16'h0000));
    check("async_rst_occ", 192'(occ), 192'(2'd0));
    check("async_rst_ready", 192'(in_ready), 192'(1'b1));
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    in_valid = 1; in_ctrl = 16'h0099; in_data = 192'h99; out_ready = 1;
    @(posedge clk); #1;
    in_valid = 0;
    @(negedge clk);
    check("post_rst_ctrl", 192'(out_ctrl), 192'(16'h0099));
    check("post_rst_data", out_data, 192'h99);
    check("post_rst_occ", 192'(occ), 192'(2'd1));
    @(posedge clk); #1;
    @(negedge clk);
    check("post_rst_drained", 192'(out_valid), 192'(1'b0));
    @(posedge clk); #1;

    // random traffic on both builds against a FIFO model of capacity 2 / 1
    rst_n = 1'b0; #1 rst_n = 1'b1;
    q0.delete(); q1.delete();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      logic er0, er1, ev0, ev1;
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 15) == 0);
      in_ctrl   = 16'($urandom);
      in_data   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      in_valid_s  = ($urandom_range(0, 9) < 7);
      out_ready_s = ($urandom_range(0, 9) < 6);
      flush_s     = ($urandom_range(0, 15) == 0);
      in_ctrl_s   = 16'($urandom);
      in_data_s   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      er0 = (q0.size() < 2);
      ev0 = (q0.size() > 0);
      er1 = (q1.size() == 0) || out_ready_s;
      ev1 = (q1.size() > 0);
      check("rnd_valid", 192'(out_valid), 192'(ev0));
      check("rnd_ready", 192'(in_ready), 192'(er0));
      check("rnd_occ", 192'(occ), 192'(q0.size()));
      check("rnd_ctrl", 192'(out_ctrl), ev0 ? 192'(q0[0].c) : 192'(16'h0));
      if (ev0) check("rnd_data", out_data, q0[0].d);
      check("rnd_s_valid", 192'(out_valid_s), 192'(ev1));
      check("rnd_s_ready", 192'(in_ready_s), 192'(er1));
      check("rnd_s_occ", 192'(occ_s), 192'(q1.size()));
      check("rnd_s_ctrl", 192'(out_ctrl_s), ev1 ? 192'(q1[0].c) : 192'(16'h0));
      if (ev1) check("rnd_s_data", out_data_s, q1[0].d);
      if (flush) q0.delete();
      else begin
        if (ev0 && out_ready) void'(q0.pop_front());
        if (in_valid && er0) q0.push_back({in_ctrl, in_data});
      end
      if (flush_s) q1.delete();
      else begin
        if (ev1 && out_ready_s) void'(q1.pop_front());
        if (in_valid_s && er1) q1.push_back({in_ctrl_s, in_data_s});
      end
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/riscv_pipe_skid_register.md
Name: riscv_pipe_skid_register

Overview:
Generic, parametrised pipeline-stage register for the pipelined RV32I core. It replaces the fixed-field, enable-only stage registers with a valid/ready stage. The stage carries a control bundle and a data bundle, supports synchronous flush (bubble insertion), and can be built as a 2-entry skid buffer so upstream ready is registered. It sits between any two pipeline stages (F/D, D/E, E/M, M/W); the top level packs and unpacks the fields.

Parameters:
CTRL_WIDTH, 16, width of the control bundle (wr_en, mem_wr_en, src selects, alu_ctrl, ...); forced to CTRL_INIT on bubble or flush.
DATA_WIDTH, 192, width of the data bundle (pc, rs data, imm, addresses, ...); never masked.
CTRL_INIT, {CTRL_WIDTH{1'b0}}, control value for reset, bubble and flush; must make the stage architecturally inert.
DATA_INIT, {DATA_WIDTH{1'b0}}, data register value at reset.
SKID_EN, 1, 1 = two-entry skid buffer with registered o_in_ready; 0 = single register with combinational o_in_ready.

Ports:
i_clk  input  1  clock, rising edge.
i_rstn  input  1  asynchronous active-low reset.
i_flush  input  1  synchronous flush; discards all held beats.
i_in_valid  input  1  upstream beat valid.
o_in_ready  output  1  stage can accept a beat this cycle.
i_in_ctrl  input  CTRL_WIDTH  upstream control bundle.
i_in_data  input  DATA_WIDTH  upstream data bundle.
o_out_valid  output  1  downstream beat valid.
i_out_ready  input  1  downstream accepts the beat.
o_out_ctrl  output  CTRL_WIDTH  control bundle; CTRL_INIT whenever o_out_valid=0.
o_out_data  output  DATA_WIDTH  data bundle (don't-care when o_out_valid=0).
o_occupancy  output  2  number of beats held (0..2; 0..1 when SKID_EN=0).

Behaviour:
- Definitions: in_fire = i_in_valid & o_in_ready; out_fire = o_out_valid & i_out_ready.
- Reset (async, i_rstn=0):
  - All valid bits clear, so o_out_valid=0 and o_occupancy=0.
  - Control registers go to CTRL_INIT, data registers to DATA_INIT.
  - o_in_ready=1 for both SKID_EN values.
  - Reset mid-transfer drops every held beat, with no partial state.
- Latency: 1 cycle from in_fire to o_out_valid. Sustained throughput is 1 beat/cycle while i_out_ready=1.
- Ordering: beats leave in arrival order. No beat is lost or duplicated except by flush or reset.
- Bubble masking: o_out_ctrl = o_out_valid ? main_ctrl : CTRL_INIT. o_out_data is always main_data.
- SKID_EN=1: registered state is main (valid, ctrl, data) plus skid (valid, ctrl, data). o_in_ready = ~skid_valid, driven from a flop with no combinational path from i_out_ready.
  - EMPTY (occ 0): in_fire -> FULL, main<=in.
  - FULL (occ 1):
    - in_fire & out_fire -> FULL, main<=in.
    - in_fire & !out_fire -> SKID, skid<=in.
    - !in_fire & out_fire -> EMPTY.
    - Otherwise hold.
  - SKID (occ 2): o_in_ready=0. out_fire -> FULL, main<=skid, skid_valid<=0. Otherwise hold.
- SKID_EN=0: single main entry. o_in_ready = ~main_valid | i_out_ready (combinational).
  - in_fire loads main.
  - out_fire & !in_fire clears main_valid.
  - Occupancy is 0 or 1.
- Flush (i_flush=1 at a clock edge):
  - Next state is EMPTY; main_valid and skid_valid clear.
  - Control registers go to CTRL_INIT; data registers hold.
  - Flush beats a simultaneous in_fire: the incoming beat is dropped, and upstream must treat it as consumed.
  - An out_fire in the flush cycle still counts as delivered downstream.
  - o_in_ready is not gated by i_flush.
- Held values: when no state change occurs, all registers hold. Ctrl and data never change while o_out_valid=1 & i_out_ready=0 (stable-under-stall rule).

Test Plan:
1. Reset then stream: i_out_ready=1, in ctrl/data = 0x0001/1, 0x0002/2, 0x0003/3 on consecutive cycles -> out valid one cycle later with 1,2,3 back-to-back; occupancy stays 1; o_in_ready=1 throughout.
2. Backpressure fill (SKID_EN=1): i_out_ready=0, send A=0x11 then B=0x22 -> occupancy 1 then 2, o_in_ready=0 after B, out holds A stable. Offer C=0x33 while full -> C not accepted. Release ready -> out A, B, then C after C is accepted; no loss or duplication.
3. Flush in SKID state: hold A,B, assert i_flush with i_in_valid=1 carrying 0x44 -> next cycle o_out_valid=0, o_out_ctrl=CTRL_INIT, occupancy 0, o_in_ready=1; 0x44 never appears at the output.
4. Simultaneous in/out in FULL: main=A, i_out_ready=1, send B -> A delivered, main=B next cycle, occupancy remains 1.
5. SKID_EN=0 build: i_out_ready=0 with main full -> o_in_ready=0 the same cycle. Raise i_out_ready -> o_in_ready=1 combinationally, with pass-through at 1 beat/cycle.
6. Async reset mid-operation: occupancy 2, pull i_rstn low between clock edges -> o_out_valid=0, o_out_ctrl=CTRL_INIT and occupancy 0 immediately, before the next edge; normal streaming resumes after release.
